// File: rtl/qam_ofdm_pkg.sv
// Shared types for the QAM/OFDM chain: bin classes, filler FSM states and the
// packed IQ sample layout {Q[31:16], I[15:0]}.
package qam_ofdm_pkg;

    typedef enum logic [1:0] {
        BIN_NULL,
        BIN_PILOT,
        BIN_DATA
    } bin_class_t;

    typedef enum logic [1:0] {
        ST_RST,
        ST_IDLE,
        ST_SYMBOL
    } state_t;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] i;
    } iq_t;

endpackage

// File: rtl/eb2a.sv
// Two-entry elastic buffer with registered ready/valid, so the downstream
// ready never reaches the upstream ready combinationally.
module eb2a #(
    parameter int T_0_WIDTH = 33,
    parameter int I_0_WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rstf,
    input  logic [T_0_WIDTH-1:0] t_0_data,
    input  logic                 t_0_valid,
    output logic                 t_0_ready,
    output logic [I_0_WIDTH-1:0] i_0_data,
    output logic                 i_0_valid,
    input  logic                 i_0_ready
);

    logic [T_0_WIDTH-1:0] mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic                 push;
    logic                 pop;

    assign t_0_ready = (count != 2'd2);
    assign i_0_valid = (count != 2'd0);
    assign i_0_data  = mem[rd_ptr];
    assign push      = t_0_valid && t_0_ready;
    assign pop       = i_0_valid && i_0_ready;

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= t_0_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qam_subcarrier_filler.sv
// Lays mapped IQ samples onto the null/pilot/data bins of OFDM symbols.
// Define SUBCARRIER_PILOT_EN to insert pilot bins; otherwise the whole occupied region is data.
module qam_subcarrier_filler
    import qam_ofdm_pkg::*;
#(
    parameter int          FFT_SIZE      = 64,
    parameter int          DATA_LO       = 4,
    parameter int          DATA_BINS     = 52,
    parameter int          PILOT_SPACING = 13,
    parameter logic [31:0] PILOT_VALUE   = 32'h0000_5A82
) (
    input  logic        clk,
    input  logic        rstf,
    input  logic [31:0] t_data,
    input  logic        t_last,
    input  logic        t_valid,
    output logic        t_ready,
    output logic [31:0] i_data,
    output logic        i_last,
    output logic        i_valid,
    input  logic        i_ready,
    output logic [15:0] sym_cnt
);

    localparam int BW = $clog2(FFT_SIZE);
    localparam logic [BW-1:0] BIN_FIRST    = BW'(DATA_LO);
    localparam logic [BW-1:0] BIN_END      = BW'(DATA_LO + DATA_BINS - 1);
    localparam logic [BW-1:0] BIN_MAX      = BW'(FFT_SIZE - 1);
    localparam logic [BW-1:0] PILOT_RELOAD = BW'(PILOT_SPACING - 1);

`ifdef SUBCARRIER_PILOT_EN
    localparam bit PILOT_EN = 1'b1;
`else
    localparam bit PILOT_EN = 1'b0;
`endif

    state_t     state;
    state_t     state_nxt;
    bin_class_t bin_class;
    iq_t        push_sample;
    logic [BW-1:0] bin;
    logic [BW-1:0] pilot_cnt;
    logic       drain;
    logic       eff_drain;
    logic       push_valid;
    logic       push_ready;
    logic       push;
    logic       push_last;
    logic       last_bin;
    logic [32:0] obuf_data;

    assign last_bin  = (bin == BIN_MAX);
    assign push      = push_valid && push_ready;
    assign push_last = last_bin && eff_drain;

    // Pilot spacing tracked by a down-counter that is zero on entry to the region.
    always_comb begin
        bin_class = BIN_NULL;
        if (bin >= BIN_FIRST && bin <= BIN_END) begin
            bin_class = (PILOT_EN && pilot_cnt == '0) ? BIN_PILOT : BIN_DATA;
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:    state_nxt = ST_IDLE;
            ST_IDLE:   if (t_valid) state_nxt = ST_SYMBOL;
            ST_SYMBOL: if (push && push_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_RST;
        endcase
    end

    // eff_drain folds in a t_last accepted on the current bin.
    always_comb begin
        push_valid  = 1'b0;
        push_sample = '0;
        t_ready     = 1'b0;
        eff_drain   = drain;
        if (state == ST_SYMBOL) begin
            case (bin_class)
                BIN_PILOT: begin
                    push_valid  = 1'b1;
                    push_sample = PILOT_VALUE;
                end
                BIN_DATA: begin
                    if (!drain) begin
                        push_valid  = t_valid;
                        push_sample = t_data;
                        t_ready     = push_ready;
                        eff_drain   = t_last;
                    end else begin
                        push_valid = 1'b1;
                    end
                end
                default: push_valid = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstf) begin
        if (!rstf) begin
            bin       <= '0;
            pilot_cnt <= '0;
            drain     <= 1'b0;
            sym_cnt   <= '0;
        end else if (push) begin
            if (last_bin) begin
                bin       <= '0;
                pilot_cnt <= '0;
                drain     <= 1'b0;
                sym_cnt   <= eff_drain ? 16'd0 : sym_cnt + 16'd1;
            end else begin
                bin <= bin + BW'(1);
                if (t_valid && t_ready && t_last) begin
                    drain <= 1'b1;
                end
                if (bin_class == BIN_NULL) begin
                    pilot_cnt <= '0;
                end else if (pilot_cnt == '0) begin
                    pilot_cnt <= PILOT_RELOAD;
                end else begin
                    pilot_cnt <= pilot_cnt - BW'(1);
                end
            end
        end
    end

    eb2a #(
        .T_0_WIDTH(33),
        .I_0_WIDTH(33)
    ) u_obuf (
        .clk       (clk),
        .rstf      (rstf),
        .t_0_data  ({push_last, push_sample}),
        .t_0_valid (push_valid),
        .t_0_ready (push_ready),
        .i_0_data  (obuf_data),
        .i_0_valid (i_valid),
        .i_0_ready (i_ready)
    );

    assign i_last = obuf_data[32];
    assign i_data = obuf_data[31:0];

endmodule

// File: tb/tb_qam_subcarrier_filler.sv
// Table-driven bench for qam_subcarrier_filler; expected bins come from a
// modulo-based reference model that honours SUBCARRIER_PILOT_EN.
module tb_qam_subcarrier_filler;

`ifdef SUBCARRIER_PILOT_EN
    localparam int PILOTS_ON = 1;
`else
    localparam int PILOTS_ON = 0;
`endif

    logic        clk;
    logic        rstf;
    logic [31:0] t_data;
    logic        t_last;
    logic        t_valid;
    logic        t_ready;
    logic [31:0] i_data;
    logic        i_last;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] sym_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int nsamp;
        int gap_pct;
        int rdy_pct;
        int stall_last;
        int exp_outputs;
    } vec_t;

    vec_t vecs[16];
    logic [31:0] smp[$];
    logic [32:0] expq[$];

    qam_subcarrier_filler dut (
        .clk     (clk),
        .rstf    (rstf),
        .t_data  (t_data),
        .t_last  (t_last),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .sym_cnt (sym_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame: ceil(n / data-bins-per-symbol) symbols, pilots by modulo.
    task automatic buildFrame(input int n, input int fnum);
        int dps;
        int nsym;
        int k;
        logic [31:0] v;
        dps = PILOTS_ON ? 48 : 52;
        nsym = (n + dps - 1) / dps;
        k = 0;
        smp.delete();
        expq.delete();
        for (int j = 0; j < n; j++) smp.push_back({16'(fnum), 16'(j + 1)});
        for (int s = 0; s < nsym; s++) begin
            for (int b = 0; b < 64; b++) begin
                v = 32'h0;
                if (b >= 4 && b < 56) begin
                    if (PILOTS_ON != 0 && ((b - 4) % 13) == 0) v = 32'h0000_5A82;
                    else if (k < n) begin
                        v = smp[k];
                        k++;
                    end
                end
                expq.push_back({(s == nsym - 1 && b == 63), v});
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int fnum);
        int idx;
        int oidx;
        int cyc;
        int nlast;
        int first_out;
        int last_out;
        int stall_left;
        bit full_rate;
        bit prev_hs;
        logic [31:0] prev_smp;
        idx = 0; oidx = 0; cyc = 0; nlast = 0;
        first_out = -1; last_out = -1;
        stall_left = v.stall_last;
        full_rate = (v.gap_pct == 0 && v.rdy_pct == 100 && v.stall_last == 0);
        prev_hs = 1'b0;
        prev_smp = '0;
        buildFrame(v.nsamp, fnum);
        while ((oidx < expq.size() || idx < v.nsamp) && cyc < 6000) begin
            @(negedge clk);
            t_valid = (idx < v.nsamp) && ($urandom_range(0, 99) >= v.gap_pct);
            t_data  = (idx < v.nsamp) ? smp[idx] : 32'h0;
            t_last  = (idx == v.nsamp - 1);
            if (idx == v.nsamp - 1 && stall_left > 0) begin
                i_ready = 1'b0;
                stall_left--;
            end else begin
                i_ready = ($urandom_range(0, 99) < v.rdy_pct);
            end
            #1;
            if (prev_hs) begin
                checkOutput("latency_valid", 64'(i_valid), 64'd1);
                checkOutput("latency_data", 64'(i_data), 64'(prev_smp));
            end
            prev_hs  = full_rate && t_valid && t_ready;
            prev_smp = t_data;
            if (t_valid && t_ready) idx++;
            if (i_valid) begin
                if (oidx >= expq.size()) begin
                    checkOutput("extra_output", 64'(oidx), 64'(expq.size() - 1));
                end else begin
                    checkOutput("bin_data", 64'({i_last, i_data}), 64'(expq[oidx]));
                    if (oidx % 64 == 0 && oidx > 0)
                        checkOutput("sym_cnt_mid", 64'(sym_cnt), 64'(oidx / 64));
                end
                if (i_ready) begin
                    if (i_last) nlast++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                    oidx++;
                end
            end
            cyc++;
        end
        checkOutput("output_count", 64'(oidx), 64'(v.exp_outputs));
        checkOutput("inputs_consumed", 64'(idx), 64'(v.nsamp));
        checkOutput("i_last_count", 64'(nlast), 64'd1);
        checkOutput("sym_cnt_end", 64'(sym_cnt), 64'd0);
        if (full_rate) checkOutput("throughput", 64'(last_out - first_out + 1), 64'(v.exp_outputs));
        t_valid = 1'b0;
        t_last  = 1'b0;
        for (int q = 0; q < 3; q++) begin
            @(negedge clk);
            i_ready = 1'b1;
            #1;
            checkOutput("no_extra_output", 64'(i_valid), 64'd0);
        end
    endtask

    task automatic resetMidSymbol();
        int oidx;
        int cyc;
        oidx = 0;
        cyc = 0;
        buildFrame(48, 99);
        while (oidx < 30 && cyc < 200) begin
            @(negedge clk);
            t_valid = (oidx < 60);
            t_data  = smp[0];
            t_last  = 1'b0;
            i_ready = 1'b1;
            #1;
            if (i_valid && i_ready) oidx++;
            cyc++;
        end
        checkOutput("reset_reach_bin30", 64'(oidx), 64'd30);
        rstf    = 1'b0;
        t_valid = 1'b0;
        #1;
        checkOutput("midrst_i_valid", 64'(i_valid), 64'd0);
        checkOutput("midrst_t_ready", 64'(t_ready), 64'd0);
        checkOutput("midrst_sym_cnt", 64'(sym_cnt), 64'd0);
        checkOutput("midrst_i_last", 64'(i_last), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("midrst_i_valid_edge", 64'(i_valid), 64'd0);
        @(negedge clk);
        rstf = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{48,  0, 100, 0, 64};
        vecs[1]  = '{50,  0, 100, 0, PILOTS_ON ? 128 : 64};
        vecs[2]  = '{52,  0, 100, 0, PILOTS_ON ? 128 : 64};
        vecs[3]  = '{1,   0, 100, 0, 64};
        vecs[4]  = '{97,  0, 100, 0, PILOTS_ON ? 192 : 128};
        vecs[5]  = '{48,  0, 100, 8, 64};
        vecs[6]  = '{20,  30, 50, 0, 64};
        vecs[7]  = '{48,  30, 50, 0, 64};
        vecs[8]  = '{49,  30, 50, 0, PILOTS_ON ? 128 : 64};
        vecs[9]  = '{60,  30, 50, 0, 128};
        vecs[10] = '{104, 30, 50, 0, PILOTS_ON ? 192 : 128};
        vecs[11] = '{7,   30, 50, 0, 64};
        vecs[12] = '{96,  30, 50, 0, 128};
        vecs[13] = '{53,  30, 50, 0, 128};
        vecs[14] = '{100, 30, 50, 0, PILOTS_ON ? 192 : 128};
        vecs[15] = '{30,  30, 50, 0, 64};

        rstf    = 1'b0;
        t_valid = 1'b0;
        t_last  = 1'b0;
        t_data  = 32'h0;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_t_ready", 64'(t_ready), 64'd0);
        checkOutput("rst_i_valid", 64'(i_valid), 64'd0);
        checkOutput("rst_i_data", 64'(i_data), 64'd0);
        checkOutput("rst_i_last", 64'(i_last), 64'd0);
        checkOutput("rst_sym_cnt", 64'(sym_cnt), 64'd0);
        @(negedge clk);
        rstf = 1'b1;

        for (int f = 0; f < 16; f++) begin
            applyStimulus(vecs[f], f);
        end

        resetMidSymbol();
        applyStimulus(vecs[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qam_subcarrier_filler.md
# qam_subcarrier_filler

Downstream stage of the QAM mapper: consumes the 32-bit mapped IQ sample stream and lays it onto the bins of one OFDM symbol, emitting exactly FFT_SIZE samples per symbol in bin order (null, pilot or data) for the IFFT. A frame (t_last-terminated) spans whole symbols; data bins after the last input sample are zero-padded, and the final bin of the frame carries i_last.

## Interface
- FFT_SIZE, 64: bins per symbol; power of two, 16..4096.
- DATA_LO, 4: first bin of the occupied region.
- DATA_BINS, 52: width of the occupied region; DATA_LO+DATA_BINS ≤ FFT_SIZE.
- PILOT_SPACING, 13: pilot when (bin−DATA_LO) mod PILOT_SPACING == 0; ≥2.
- PILOT_VALUE, 32'h0000_5A82: pilot sample {Q[31:16], I[15:0]}.
- clk  in  1  clock.
- rstf  in  1  asynchronous, active-low reset.
- t_data  in  32  mapped sample {Q[31:16], I[15:0]}.
- t_last  in  1  last sample of frame.
- t_valid  in  1  input valid.
- t_ready  out  1  input accepted when t_valid&&t_ready.
- i_data  out  32  bin sample.
- i_last  out  1  final bin of final symbol of frame.
- i_valid  out  1  output valid.
- i_ready  in  1  downstream ready.
- sym_cnt  out  16  symbols completed in current frame; wraps at 2^16.

## Operation
- States: RST → IDLE (always, one cycle); IDLE → SYMBOL when t_valid (nothing consumed in IDLE); SYMBOL → SYMBOL (bin FFT_SIZE−1 pushed, drain=0, bin←0, sym_cnt+1); SYMBOL → IDLE (bin FFT_SIZE−1 pushed with drain=1, drain←0, sym_cnt←0).
- Bin class from bin counter: null outside [DATA_LO, DATA_LO+DATA_BINS); pilot by a region down-counter reloaded to PILOT_SPACING−1 at each pilot (no divider); otherwise data.
- Null bin: push 32'h0. Pilot bin: push PILOT_VALUE. Neither consumes input.
- Data bin, drain=0: t_ready=buffer-ready; push t_data on handshake; no t_valid → stall, bin held, no push. t_last accepted → drain←1.
- Data bin, drain=1: push 32'h0, t_ready=0.
- i_last pushed with bin FFT_SIZE−1 only when drain=1 at that push (includes t_last accepted on that very bin).
- t_last on the final data bin of a symbol: frame ends with that symbol, no padding symbol added.
- Bin counter advances only when a push is accepted by the output buffer; wraps FFT_SIZE−1 → 0.
- Input not valid at bin 0 of a following symbol: null/pilot bins still emitted, stall at first data bin.

## Timing
- Reset values: t_ready 0, i_valid 0, i_data 0, i_last 0, sym_cnt 0, state RST, bin 0, drain 0.
- Latency: input handshake at cycle n → sample on i_data with i_valid at n+1.
- Throughput: one bin per cycle with i_ready held high and t_valid held high.
- i_data/i_last stable while i_valid&&!i_ready; no combinational path i_ready → t_ready beyond one buffer stage.
- Reset asserted mid-symbol: all state cleared immediately; buffered samples discarded; no partial-symbol completion after release.
- Output bins per frame always a multiple of FFT_SIZE.

## Configuration
- SUBCARRIER_PILOT_EN defined: pilot bins inserted as above (defaults: pilots at bins 4,17,30,43; 48 data bins/symbol).
- Undefined: pilot logic removed, PILOT_SPACING/PILOT_VALUE ignored, every occupied-region bin is data (52 data bins/symbol).

## Structure
- Shared package qam_ofdm_pkg: bin-class enum {BIN_NULL, BIN_PILOT, BIN_DATA}, state enum, IQ sample typedef {Q,I} 16+16.
- One sub-module: eb2a (T_0_WIDTH/I_0_WIDTH 33 = {last,data}) as output buffer; bin classification and FSM in this module.

## Test plan
- Defaults, pilots on, 48 samples 1..48 with t_last on 48 → 64 outputs: bins 0–3 zero, bin 4 PILOT_VALUE, bins 5–16 = 1..12, bin 17 pilot, …, bins 56–63 zero, i_last only on bin 63, sym_cnt 0 after.
- 50 samples, last on 50 → 128 outputs; symbol 2 bins 5,6 = 49,50, remaining data bins zero, i_last on output 128.
- Pilots off (macro undefined), 52 samples → bins 4–55 = samples, no pilots, one symbol, i_last bin 63.
- Random i_ready (50%) and t_valid gaps over 10 frames → output matches model bin-for-bin, no drops/duplicates, data held during stall.
- t_last on sample 48 while i_ready=0 → frame still one symbol; i_last appears exactly once.
- rstf pulsed at bin 30 → i_valid 0 next edge, t_ready 0, sym_cnt 0; next frame starts cleanly at bin 0.
